// File: rtl/mips_muldiv.sv
// mips_muldiv
// Multi-cycle multiply/divide unit with private HI/LO registers, sitting
// beside the execute-stage ALU. Handles MULT, MULTU, DIV, DIVU, MTHI, MTLO.
// Multiply is radix-2 shift-add and divide is restoring division, both on
// operand magnitudes. Signs are applied in a final fix-up cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   md_valid     request strobe, taken only while md_busy is low
//   md_op        0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6/7 ignored)
//   md_op_x      multiplicand / dividend / MTHI-MTLO source
//   md_op_y      multiplier / divisor
//   md_busy      high while a multiply/divide is in flight
//   md_done      one-cycle pulse, new HI/LO already visible
//   md_div_zero  sticky divide-by-zero flag
//   md_hi        HI register (product upper half / remainder)
//   md_lo        LO register (product lower half / quotient)
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_valid,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] md_op_x,
    input  logic [WIDTH-1:0] md_op_y,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_div_zero,
    output logic [WIDTH-1:0] md_hi,
    output logic [WIDTH-1:0] md_lo
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] iter;

    // Operation context captured at accept
    logic [WIDTH-1:0]   xmag;
    logic [WIDTH-1:0]   ymag;
    logic [WIDTH-1:0]   x_orig;
    logic [2*WIDTH-1:0] acc;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               dz;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] a,
                                                  input logic neg);
        return neg ? -a : a;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] a,
                                                       input logic neg);
        return neg ? -a : a;
    endfunction

    // Request decode
    logic             accept;
    logic             op_is_md;
    logic             op_is_div;
    logic             op_signed;
    logic             x_neg;
    logic             y_neg;
    logic [WIDTH-1:0] x_abs;
    logic [WIDTH-1:0] y_abs;

    // busy is high exactly when the FSM is outside IDLE
    assign accept    = (state == S_IDLE) && md_valid;
    assign op_is_md  = ~md_op[2];
    assign op_is_div = md_op[1];
    assign op_signed = ~md_op[0];
    assign x_neg     = op_signed & md_op_x[WIDTH-1];
    assign y_neg     = op_signed & md_op_y[WIDTH-1];
    assign x_abs     = cond_neg(md_op_x, x_neg);
    assign y_abs     = cond_neg(md_op_y, y_neg);

    // Iteration step
    // Multiply: acc = {partial product, remaining multiplier bits}; add |x|
    // into the upper half when the current multiplier LSB is set, then shift
    // the whole thing right with the carry.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? xmag : '0)};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {rem, quo}. The shifted remainder needs one extra bit;
    // because rem < |y| holds between steps, the top bit of the difference
    // is a clean borrow indicator. With |y| = 0 the result is overridden.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_borrow;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift  = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff   = div_shift - {1'b0, ymag};
    assign div_borrow = div_diff[WIDTH];
    assign div_next   = div_borrow ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    // Sign fix-up
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign prod_fixed = cond_neg_2w(acc, neg_lo);
    assign quo_fixed  = cond_neg(acc[WIDTH-1:0], neg_lo);
    assign rem_fixed  = cond_neg(acc[2*WIDTH-1:WIDTH], neg_hi);

    // Datapath registers: loaded at accept, stepped in CALC, no reset needed
    always_ff @(posedge clk) begin
        if (accept && op_is_md) begin
            xmag   <= x_abs;
            ymag   <= y_abs;
            x_orig <= md_op_x;
            acc    <= {{WIDTH{1'b0}}, (op_is_div ? x_abs : y_abs)};
            is_div <= op_is_div;
            neg_lo <= x_neg ^ y_neg;
            neg_hi <= x_neg;
            dz     <= op_is_div && (md_op_y == '0);
        end else if (state == S_CALC) begin
            acc <= is_div ? div_next : mul_next;
        end
    end

    // Control FSM and architectural HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            iter        <= '0;
            md_busy     <= 1'b0;
            md_done     <= 1'b0;
            md_div_zero <= 1'b0;
            md_hi       <= '0;
            md_lo       <= '0;
        end else begin
            md_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op_is_md) begin
                            state       <= S_CALC;
                            iter        <= '0;
                            md_busy     <= 1'b1;
                            md_div_zero <= 1'b0;
                        end else if (md_op == OP_MTHI) begin
                            md_hi <= md_op_x;
                        end else if (md_op == OP_MTLO) begin
                            md_lo <= md_op_x;
                        end
                    end
                end
                S_CALC: begin
                    iter <= iter + 1'b1;
                    if (iter == LAST_ITER) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        if (dz) begin
                            md_lo <= '1;
                            md_hi <= x_orig;
                        end else begin
                            md_lo <= quo_fixed;
                            md_hi <= rem_fixed;
                        end
                    end else begin
                        {md_hi, md_lo} <= prod_fixed;
                    end
                    md_div_zero <= dz & is_div;
                    md_busy     <= 1'b0;
                    md_done     <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
module tb_mips_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] md_op_x, md_op_y;
    logic        md_busy, md_done, md_div_zero;
    logic [31:0] md_hi, md_lo;

    logic        v8;
    logic [2:0]  op8;
    logic [7:0]  x8, y8;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    mips_muldiv #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .md_valid(md_valid), .md_op(md_op),
        .md_op_x(md_op_x), .md_op_y(md_op_y), .md_busy(md_busy),
        .md_done(md_done), .md_div_zero(md_div_zero), .md_hi(md_hi), .md_lo(md_lo)
    );

    mips_muldiv #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .md_valid(v8), .md_op(op8),
        .md_op_x(x8), .md_op_y(y8), .md_busy(busy8),
        .md_done(done8), .md_div_zero(dz8), .md_hi(hi8), .md_lo(lo8)
    );

    int checks = 0;
    int errors = 0;

    // Reference architectural state of the 32-bit unit
    logic [31:0] m_hi, m_lo;
    logic        m_dz;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x, y, hi, lo;
        logic        dz;
    } vec_t;

    vec_t dvec [7] = '{
        '{3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0},
        '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
        '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0},
        '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0},
        '{3'd3, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0},
        '{3'd3, 32'h0000_0064, 32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 1'b1},
        '{3'd1, 32'd2,         32'd3,        32'd0,         32'd6,         1'b0}
    };

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural model using plain integer arithmetic
    task automatic model32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, q, r;
        logic [63:0] p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (op)
            3'd0: begin p = sx * sy; {m_hi, m_lo} = p; m_dz = 1'b0; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = p; m_dz = 1'b0; end
            3'd2: begin
                if (y == 32'd0) begin m_lo = '1; m_hi = x; m_dz = 1'b1; end
                else begin q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0]; m_dz = 1'b0; end
            end
            3'd3: begin
                if (y == 32'd0) begin m_lo = '1; m_hi = x; m_dz = 1'b1; end
                else begin m_lo = x / y; m_hi = x % y; m_dz = 1'b0; end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Presents one request, returns at the first cycle where busy is low
    // after the accept (the done cycle for multiply/divide).
    task automatic issue32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                           output int busy_n, output logic done_o, output logic stable_o,
                           output int done_cyc);
        int guard;
        logic [31:0] pre_hi, pre_lo;
        guard = 0;
        while (md_busy && guard < 200) begin step(); guard++; end
        pre_hi = md_hi;
        pre_lo = md_lo;
        md_valid = 1'b1; md_op = op; md_op_x = x; md_op_y = y;
        step();
        md_valid = 1'b0; md_op = 3'($urandom); md_op_x = $urandom; md_op_y = $urandom;
        busy_n = 0;
        stable_o = 1'b1;
        while (md_busy && busy_n < 200) begin
            if (md_done || md_hi !== pre_hi || md_lo !== pre_lo) stable_o = 1'b0;
            busy_n++;
            step();
        end
        done_o = md_done;
        done_cyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1; md_valid = 1'b0; md_op = 3'd0; md_op_x = '0; md_op_y = '0;
        v8 = 1'b0; op8 = 3'd0; x8 = '0; y8 = '0;
        step(); step();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", md_busy); end
        checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", md_done); end
        checks++; if (md_div_zero !== 1'b0) begin errors++; $display("FAIL reset div_zero: got %b expected 0", md_div_zero); end
        checks++; if (md_hi !== 32'd0) begin errors++; $display("FAIL reset hi: got %h expected 0", md_hi); end
        checks++; if (md_lo !== 32'd0) begin errors++; $display("FAIL reset lo: got %h expected 0", md_lo); end
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        step();
    endtask

    task automatic test_directed();
        int bn, dc;
        logic dn, st;
        for (int i = 0; i < 7; i++) begin
            issue32(dvec[i].op, dvec[i].x, dvec[i].y, bn, dn, st, dc);
            checks++; if (bn != 33) begin errors++; $display("FAIL dir[%0d] busy cycles: got %0d expected 33", i, bn); end
            checks++; if (dn !== 1'b1) begin errors++; $display("FAIL dir[%0d] done: got %b expected 1", i, dn); end
            checks++; if (st !== 1'b1) begin errors++; $display("FAIL dir[%0d] hi/lo held during busy: got %b expected 1", i, st); end
            checks++; if (md_hi !== dvec[i].hi) begin errors++; $display("FAIL dir[%0d] hi: got %h expected %h", i, md_hi, dvec[i].hi); end
            checks++; if (md_lo !== dvec[i].lo) begin errors++; $display("FAIL dir[%0d] lo: got %h expected %h", i, md_lo, dvec[i].lo); end
            checks++; if (md_div_zero !== dvec[i].dz) begin errors++; $display("FAIL dir[%0d] div_zero: got %b expected %b", i, md_div_zero, dvec[i].dz); end
            m_hi = dvec[i].hi; m_lo = dvec[i].lo; m_dz = dvec[i].dz;
        end
        step();
        checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL dir done pulse width: got %b expected 0", md_done); end
    endtask

    task automatic test_random();
        int bn, dc;
        logic dn, st;
        logic [2:0] op;
        logic [31:0] x, y;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            model32(op, x, y);
            issue32(op, x, y, bn, dn, st, dc);
            if (op <= 3'd3) begin
                checks++; if (bn != 33 || dn !== 1'b1 || st !== 1'b1) begin errors++;
                    $display("FAIL rand[%0d] op%0d timing: got busy=%0d done=%b held=%b expected busy=33 done=1 held=1", i, op, bn, dn, st); end
            end else begin
                checks++; if (bn != 0 || dn !== 1'b0) begin errors++;
                    $display("FAIL rand[%0d] op%0d no-busy: got busy=%0d done=%b expected busy=0 done=0", i, op, bn, dn); end
            end
            checks++; if (md_hi !== m_hi) begin errors++; $display("FAIL rand[%0d] op%0d x=%h y=%h hi: got %h expected %h", i, op, x, y, md_hi, m_hi); end
            checks++; if (md_lo !== m_lo) begin errors++; $display("FAIL rand[%0d] op%0d x=%h y=%h lo: got %h expected %h", i, op, x, y, md_lo, m_lo); end
            checks++; if (md_div_zero !== m_dz) begin errors++; $display("FAIL rand[%0d] op%0d div_zero: got %b expected %b", i, op, md_div_zero, m_dz); end
        end
    endtask

    task automatic test_ignore_busy();
        int guard;
        logic [31:0] x, y;
        x = $urandom; y = $urandom;
        guard = 0;
        while (md_busy && guard < 200) begin step(); guard++; end
        model32(3'd0, x, y);
        md_valid = 1'b1; md_op = 3'd0; md_op_x = x; md_op_y = y;
        step();
        md_op = 3'd4; md_op_x = 32'h0000_1234; md_op_y = $urandom;
        guard = 0;
        while (md_busy && guard < 200) begin step(); guard++; end
        checks++; if (md_done !== 1'b1) begin errors++; $display("FAIL ignore done: got %b expected 1", md_done); end
        checks++; if (md_hi !== m_hi) begin errors++; $display("FAIL ignore hi kept product: got %h expected %h", md_hi, m_hi); end
        checks++; if (md_lo !== m_lo) begin errors++; $display("FAIL ignore lo: got %h expected %h", md_lo, m_lo); end
        step();
        md_valid = 1'b0;
        m_hi = 32'h0000_1234;
        checks++; if (md_hi !== m_hi) begin errors++; $display("FAIL mthi idle hi: got %h expected %h", md_hi, m_hi); end
        checks++; if (md_lo !== m_lo) begin errors++; $display("FAIL mthi idle lo untouched: got %h expected %h", md_lo, m_lo); end
        checks++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin errors++; $display("FAIL mthi idle busy/done: got %b/%b expected 0/0", md_busy, md_done); end
        step();
        checks++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin errors++; $display("FAIL mthi idle later busy/done: got %b/%b expected 0/0", md_busy, md_done); end
    endtask

    task automatic test_back_to_back();
        int bn, dc1, dc2;
        logic dn, st;
        logic [31:0] x, y;
        x = $urandom; y = $urandom_range(1, 1000);
        model32(3'd2, x, y);
        issue32(3'd2, x, y, bn, dn, st, dc1);
        checks++; if (md_lo !== m_lo || md_hi !== m_hi) begin errors++; $display("FAIL b2b first: got %h/%h expected %h/%h", md_hi, md_lo, m_hi, m_lo); end
        x = $urandom; y = $urandom;
        model32(3'd1, x, y);
        issue32(3'd1, x, y, bn, dn, st, dc2);
        checks++; if (dc2 - dc1 != 34) begin errors++; $display("FAIL b2b spacing: got %0d expected 34", dc2 - dc1); end
        checks++; if (md_lo !== m_lo || md_hi !== m_hi) begin errors++; $display("FAIL b2b second: got %h/%h expected %h/%h", md_hi, md_lo, m_hi, m_lo); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (md_done !== 1'b0 || md_busy !== 1'b0) begin errors++; $display("FAIL b2b idle done/busy: got %b/%b expected 0/0", md_done, md_busy); end
        checks++; if (md_lo !== m_lo || md_hi !== m_hi) begin errors++; $display("FAIL b2b hold: got %h/%h expected %h/%h", md_hi, md_lo, m_hi, m_lo); end
    endtask

    task automatic test_reset_mid();
        int bn, dc;
        logic dn, st, seen;
        issue32(3'd3, 32'd5, 32'd0, bn, dn, st, dc);
        checks++; if (md_div_zero !== 1'b1) begin errors++; $display("FAIL rstmid setup div_zero: got %b expected 1", md_div_zero); end
        md_valid = 1'b1; md_op = 3'd2; md_op_x = $urandom; md_op_y = $urandom | 32'd1;
        step();
        md_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b expected 0", md_busy); end
        checks++; if (md_hi !== 32'd0 || md_lo !== 32'd0) begin errors++; $display("FAIL rstmid hi/lo: got %h/%h expected 0/0", md_hi, md_lo); end
        checks++; if (md_div_zero !== 1'b0) begin errors++; $display("FAIL rstmid div_zero: got %b expected 0", md_div_zero); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (md_done || md_busy) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid late done/busy: got %b expected 0", seen); end
    endtask

    task automatic test_width8();
        logic [7:0] ex_hi [2] = '{8'h40, 8'hFF};
        logic [7:0] ex_lo [2] = '{8'h00, 8'hFD};
        logic [2:0] ops   [2] = '{3'd0, 3'd2};
        logic [7:0] xs    [2] = '{8'h80, 8'hF9};
        logic [7:0] ys    [2] = '{8'h80, 8'h02};
        int bn, guard;
        for (int i = 0; i < 2; i++) begin
            guard = 0;
            while (busy8 && guard < 100) begin step(); guard++; end
            v8 = 1'b1; op8 = ops[i]; x8 = xs[i]; y8 = ys[i];
            step();
            v8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
            bn = 0;
            while (busy8 && bn < 100) begin bn++; step(); end
            checks++; if (bn != 9) begin errors++; $display("FAIL w8[%0d] busy cycles: got %0d expected 9", i, bn); end
            checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL w8[%0d] done: got %b expected 1", i, done8); end
            checks++; if (hi8 !== ex_hi[i] || lo8 !== ex_lo[i]) begin errors++;
                $display("FAIL w8[%0d] hi/lo: got %h/%h expected %h/%h", i, hi8, lo8, ex_hi[i], ex_lo[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Multi-cycle, parametrised multiply/divide unit with its own HI/LO result registers. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the combinational ALU in the execute stage and drives a busy flag that the pipeline control uses to stall MFHI/MFLO and any further multiply/divide while an operation is in flight. Multiply uses radix-2 shift-add on operand magnitudes; divide uses restoring division on magnitudes; signs are corrected in a final cycle.

## Interface
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- md_valid  in  1  request strobe; accepted only when md_busy is low.
- md_op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6/7 ignored (no state change).
- md_op_x  in  WIDTH  multiplicand / dividend / MTHI/MTLO source.
- md_op_y  in  WIDTH  multiplier / divisor.
- md_busy  out  1  high while a multiply/divide is in progress.
- md_done  out  1  single-cycle pulse; the new HI/LO are visible in this same cycle.
- md_div_zero  out  1  sticky flag, set by a DIV/DIVU whose divisor is 0 and cleared by the next accepted MULT/MULTU/DIV/DIVU.
- md_hi  out  WIDTH  HI register (upper product half / remainder).
- md_lo  out  WIDTH  LO register (lower product half / quotient).

## Operation
- **States:**
  - IDLE: accepts requests.
  - CALC: WIDTH iterations, one bit per cycle.
  - FIX: sign correction, then writes HI/LO.
  - Transitions: IDLE→CALC on an accepted op 0–3; CALC→FIX after the WIDTH-th iteration; FIX→IDLE unconditionally.
- **Accept:** md_valid & ~md_busy. On accept, latch op, |x|, |y|, the result sign flags and the divide-by-zero flag.
  - Signed ops take magnitudes via two's-complement negate when the MSB is set.
  - Unsigned ops use raw operands.
- **Multiply:**
  - The 2·WIDTH-bit accumulator adds |x|·2^i when bit i of |y| is 1.
  - In FIX, negate the full 2·WIDTH product if sign(x)^sign(y) on MULT.
  - {HI,LO} = product.
- **Divide (restoring):**
  - Each cycle, shift {rem, quo} left by 1 and trial-subtract |y| from rem.
  - If there is no borrow, keep the difference and set the quotient LSB to 1.
  - In FIX for DIV: negate the quotient if sign(x)^sign(y); negate the remainder if sign(x) (truncating division).
  - LO = quotient, HI = remainder.
- **Divide by zero:**
  - The divide runs the full latency.
  - Forced result: LO = all ones, HI = md_op_x (the original, unmodified dividend), for both DIV and DIVU.
  - md_div_zero is set with md_done.
- **Signed overflow** (DIV of most-negative by −1): LO = most-negative, HI = 0. This falls out of the magnitude datapath and must not be special-cased differently.
- **MTHI/MTLO:**
  - Accepted in IDLE only.
  - Write md_op_x to HI or LO at the next edge.
  - Do not assert busy or done, and do not touch md_div_zero.
- md_valid while md_busy is ignored entirely; the requester must hold and re-present it. The unit never queues a request.
- Operands are sampled only at accept; input changes during CALC/FIX have no effect.

## Timing
- **Reset:** state=IDLE; md_busy=0, md_done=0, md_div_zero=0, md_hi=0, md_lo=0.
- **Reset mid-operation:** aborts immediately at that edge; all outputs take their reset values; no md_done is produced.
- **Latency for ops 0–3:**
  - Accept at edge E0.
  - md_busy is high from E0+ through the cycle ending at edge E0+WIDTH+1 (WIDTH+1 cycles).
  - HI/LO update at edge E0+WIDTH+1.
  - md_done is high for the one cycle following that edge, and md_busy is low in that cycle.
- **Back-to-back:** a new request may be accepted in the md_done cycle, giving a throughput of one op per WIDTH+2 cycles. HI/LO keep their values until the next write.
- **MTHI/MTLO:** HI/LO are visible one cycle after the accept edge.
- md_hi and md_lo are registered outputs; the partial accumulator is never exposed on them.

## Test plan
- **MULT, WIDTH=32, x=0xFFFFFFFD (−3), y=5** → after 33 busy cycles, md_done pulses with HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **MULTU, x=y=0xFFFFFFFF** → HI=0xFFFFFFFE, LO=0x00000001. Then **DIV x=0x80000000, y=0xFFFFFFFF** → LO=0x80000000, HI=0, md_div_zero=0.
- **DIV x=−7, y=2** → LO=0xFFFFFFFD, HI=0xFFFFFFFF. **DIVU x=100, y=7** → LO=14, HI=2.
- **DIVU x=0x64, y=0** → LO=0xFFFFFFFF, HI=0x64, md_div_zero=1. A following MULTU 2·3 clears the flag → LO=6, HI=0.
- **Ignored requests:** MTHI 0x1234 presented while busy is ignored and HI holds the multiply result. The same MTHI presented in IDLE → HI=0x1234 one cycle later, with md_busy and md_done staying 0.
- **Reset and parametrisation:**
  - Assert rst at iteration 10 of a DIV → next cycle md_busy=0, HI=LO=0, and no md_done.
  - A WIDTH=8 instance running MULT 0x80·0x80 → HI=0x40, LO=0x00 with 9 busy cycles.
